// File: rtl/rect_draw_scheduler_pkg.sv
// Shared types and constants for the rectangle draw scheduler.
package rect_draw_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

endpackage

// File: rtl/rect_draw_scheduler_rr_arbiter.sv
// Combinational round-robin select: first set req bit above ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int k;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!valid && req[k]) begin
                valid    = 1'b1;
                idx      = IW'(k);
                grant[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rect_draw_scheduler.sv
// Arbitrates rectangle draw/clear requests and rasters the winner one
// pixel per clock onto the shared VGA write port.
module rect_draw_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int SCREEN_W = rect_draw_scheduler_pkg::SCREEN_W,
    parameter int SCREEN_H = rect_draw_scheduler_pkg::SCREEN_H
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*XW-1:0] topX,
    input  logic [NUM_REQ*YW-1:0] topY,
    input  logic [NUM_REQ*XW-1:0] bottomX,
    input  logic [NUM_REQ*YW-1:0] bottomY,
    input  logic [NUM_REQ*3-1:0]  colour,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    done,
    output logic                  busy,
    output logic                  plot,
    output logic [XW-1:0]         x,
    output logic [YW-1:0]         y,
    output logic [2:0]            colour_out
);
    import rect_draw_scheduler_pkg::*;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [XW-1:0] XMAX = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(SCREEN_H - 1);

    state_t state;
    logic [IW-1:0] ptr, winner;
    logic [XW-1:0] tx, bx;
    logic [YW-1:0] by;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    logic [XW-1:0] sel_tx, sel_bx, cl_bx;
    logic [YW-1:0] sel_ty, sel_by, cl_by;
    logic [2:0]    sel_col;

    assign sel_tx  = topX[int'(winner)*XW +: XW];
    assign sel_ty  = topY[int'(winner)*YW +: YW];
    assign sel_bx  = bottomX[int'(winner)*XW +: XW];
    assign sel_by  = bottomY[int'(winner)*YW +: YW];
    assign sel_col = colour[int'(winner)*3 +: 3];
    assign cl_bx   = (sel_bx > XMAX) ? XMAX : sel_bx;
    assign cl_by   = (sel_by > YMAX) ? YMAX : sel_by;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= IW'(NUM_REQ - 1);
            winner     <= '0;
            grant      <= '0;
            done       <= '0;
            busy       <= 1'b0;
            plot       <= 1'b0;
            x          <= '0;
            y          <= '0;
            colour_out <= '0;
            tx         <= '0;
            bx         <= '0;
            by         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= '0;
                    if (arb_valid) begin
                        grant  <= arb_grant;
                        ptr    <= arb_idx;
                        winner <= arb_idx;
                        busy   <= 1'b1;
                        state  <= LATCH;
                    end
                end
                LATCH: begin
                    tx         <= sel_tx;
                    bx         <= cl_bx;
                    by         <= cl_by;
                    colour_out <= sel_col;
                    // Fully off-screen or inverted rectangles finish with no pixels
                    if (sel_tx > cl_bx || sel_ty > cl_by) begin
                        done  <= grant;
                        state <= DONE;
                    end else begin
                        x     <= sel_tx;
                        y     <= sel_ty;
                        plot  <= 1'b1;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if (x == bx) begin
                        x <= tx;
                        if (y == by) begin
                            plot  <= 1'b0;
                            done  <= grant;
                            state <= DONE;
                        end else begin
                            y <= y + 1'b1;
                        end
                    end else begin
                        x <= x + 1'b1;
                    end
                end
                DONE: begin
                    done  <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_draw_scheduler.sv
// Self-checking bench for rect_draw_scheduler with a pixel-list reference model.
module tb_rect_draw_scheduler;

    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*XW-1:0] topX, bottomX;
    logic [N*YW-1:0] topY, bottomY;
    logic [N*3-1:0]  colour;
    logic [N-1:0]    grant, done;
    logic            busy, plot;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [2:0]      colour_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ptr_m;

    rect_draw_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .topX       (topX),
        .topY       (topY),
        .bottomX    (bottomX),
        .bottomY    (bottomY),
        .colour     (colour),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .colour_out (colour_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic set_rect(input int r, input int tx, input int ty,
                            input int bx, input int by, input int col);
        topX[r*XW +: XW]    = XW'(tx);
        topY[r*YW +: YW]    = YW'(ty);
        bottomX[r*XW +: XW] = XW'(bx);
        bottomY[r*YW +: YW] = YW'(by);
        colour[r*3 +: 3]    = 3'(col);
    endtask

    // Single requester draws; model is the expected raster list of clipped pixels.
    task automatic do_draw(input int r, input int tx, input int ty,
                           input int bx, input int by, input int col,
                           input int chg_at, input int chg_x, input string tag);
        int ex[$];
        int ey[$];
        int cbx, cby, p, k, t;
        bit fin;
        logic [N-1:0] oh;
        set_rect(r, tx, ty, bx, by, col);
        cbx = (bx > 159) ? 159 : bx;
        cby = (by > 119) ? 119 : by;
        for (int yy = ty; yy <= cby; yy++)
            for (int xx = tx; xx <= cbx; xx++) begin
                ex.push_back(xx);
                ey.push_back(yy);
            end
        p = ex.size();
        oh = '0;
        oh[r] = 1'b1;
        @(negedge clk);
        req[r] = 1'b1;
        t = cyc;
        k = 0;
        fin = 0;
        for (int n = 0; n < p + 12 && !fin; n++) begin
            @(negedge clk);
            if (cyc - t == 1) begin
                n_cmp++;
                if (grant !== oh) begin
                    n_bad++;
                    $display("FAIL %s grant: got %b want %b", tag, grant, oh);
                end
            end
            if (plot === 1'b1) begin
                n_cmp++;
                if (k >= p) begin
                    n_bad++;
                    $display("FAIL %s extra pixel: got (%0d,%0d) beyond %0d pixels",
                             tag, x, y, p);
                end else if (int'(x) !== ex[k] || int'(y) !== ey[k] ||
                             int'(colour_out) !== col || cyc - t != 2 + k) begin
                    n_bad++;
                    $display("FAIL %s pixel %0d: got (%0d,%0d) c%0d at +%0d want (%0d,%0d) c%0d at +%0d",
                             tag, k, x, y, colour_out, cyc - t, ex[k], ey[k], col, 2 + k);
                end
                k++;
                if (chg_at >= 0 && k == chg_at)
                    topX[r*XW +: XW] = XW'(chg_x);
            end
            if (done !== '0) begin
                n_cmp++;
                if (done !== oh || cyc - t != 2 + p || k != p) begin
                    n_bad++;
                    $display("FAIL %s done: got %b at +%0d after %0d px want %b at +%0d after %0d px",
                             tag, done, cyc - t, k, oh, 2 + p, p);
                end
                fin = 1;
            end
        end
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got no done want done after %0d px", tag, p);
        end
        @(posedge clk);
        #1 req[r] = 1'b0;
        ptr_m = r;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || grant !== '0) begin
            n_bad++;
            $display("FAIL %s idle: got busy=%b grant=%b want 0/0", tag, busy, grant);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ptr_m = N - 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = '0;
        topX = '0; topY = '0; bottomX = '0; bottomY = '0; colour = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (grant !== '0 || done !== '0 || busy !== 1'b0 || plot !== 1'b0) begin
            n_bad++;
            $display("FAIL reset ctl: got g=%b d=%b b=%b p=%b want 0", grant, done, busy, plot);
        end
        n_cmp++;
        if (x !== '0 || y !== '0 || colour_out !== '0) begin
            n_bad++;
            $display("FAIL reset pix: got (%0d,%0d) c%0d want (0,0) c0", x, y, colour_out);
        end
        reset = 1'b0;
        ptr_m = N - 1;
    endtask

    task automatic test_basic();
        do_draw(1, 10, 10, 12, 11, 0, -1, 0, "basic");
    endtask

    task automatic rr_batch(input logic [N-1:0] mask, output int order[$]);
        logic [N-1:0] rem, d;
        int w, kk;
        rem = mask;
        @(negedge clk);
        req = req | mask;
        for (int n = 0; n < 200 && rem != '0; n++) begin
            @(negedge clk);
            if (done !== '0) begin
                w = -1;
                for (int j = 1; j <= N; j++) begin
                    kk = (ptr_m + j) % N;
                    if (w < 0 && rem[kk]) w = kk;
                end
                d = done;
                n_cmp++;
                if (d !== N'(1 << w)) begin
                    n_bad++;
                    $display("FAIL rr order: got done=%b want %b", d, N'(1 << w));
                end
                order.push_back(w);
                ptr_m = w;
                @(posedge clk);
                #1;
                req = req & ~d;
                rem = rem & ~d;
                if (d == '0) rem = '0;
            end
        end
        if (rem != '0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rr timeout: got pending=%b want 0000", rem);
            req = '0;
        end
    endtask

    task automatic test_round_robin();
        int ord[$];
        int ord2[$];
        apply_reset();
        for (int i = 0; i < N; i++) set_rect(i, 5 * i, 5 * i, 5 * i, 5 * i, i);
        rr_batch(4'b1111, ord);
        n_cmp++;
        if (ord.size() != 4 || ord[0] != 0 || ord[1] != 1 || ord[2] != 2 || ord[3] != 3) begin
            n_bad++;
            $display("FAIL rr first pass: got %p want '{0,1,2,3}", ord);
        end
        rr_batch(4'b0101, ord2);
        n_cmp++;
        if (ord2.size() != 2 || ord2[0] != 0 || ord2[1] != 2) begin
            n_bad++;
            $display("FAIL rr second pass: got %p want '{0,2}", ord2);
        end
    endtask

    task automatic test_clip();
        do_draw(0, 158, 118, 170, 125, 7, -1, 0, "clip");
    endtask

    task automatic test_degenerate();
        do_draw(3, 20, 5, 19, 5, 7, -1, 0, "degenerate");
    endtask

    task automatic test_reset_mid_draw();
        int cnt;
        bit hit;
        set_rect(2, 30, 40, 41, 49, 5);
        @(negedge clk);
        req[2] = 1'b1;
        cnt = 0;
        hit = 0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clk);
            if (plot === 1'b1) cnt++;
            if (cnt == 30) hit = 1;
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (!hit || plot !== 1'b0 || grant !== '0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset drop: got hit=%0d plot=%b grant=%b busy=%b want 1/0/0/0",
                     hit, plot, grant, busy);
        end
        req[2] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ptr_m = N - 1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== '0 || plot !== 1'b0) begin
                n_bad++;
                $display("FAIL midreset quiet: got done=%b plot=%b want 0/0", done, plot);
            end
        end
        do_draw(2, 30, 40, 41, 49, 5, -1, 0, "redraw");
    endtask

    task automatic test_latch_ignore();
        do_draw(2, 40, 20, 43, 22, 3, 3, 60, "latch");
    endtask

    task automatic test_random();
        int r, tx, ty, dx, dy, col;
        for (int i = 0; i < 20; i++) begin
            r   = $urandom_range(N - 1, 0);
            tx  = $urandom_range(170, 1);
            dx  = $urandom_range(5, 0);
            ty  = $urandom_range(122, 1);
            dy  = $urandom_range(4, 0);
            col = $urandom_range(7, 0);
            do_draw(r, tx, ty, tx + dx - 1, ty + dy - 1, col, -1, 0,
                    $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_clip();
        test_degenerate();
        test_reset_mid_draw();
        test_latch_ignore();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
